pio_blink_ctrl: RTL and testbench
=================================

PIO_BLINK_CTRL -- requirements
Module: pio_blink_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_PERIOD, 32'd50_000_000, the reset value of the PERIOD register in clk cycles.
REQ-002 SHALL have parameter DEFAULT_PATTERN, 32'h5555_5555, the reset value of the PATTERN register.
REQ-003 clk  in  1  clock; all state is rising-edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 s_address  in  2  CSR word select: 0 CTRL, 1 PERIOD, 2 PATTERN, 3 STATUS.
REQ-006 s_chipselect, s_write_n  in  1 each  CSR Avalon-MM slave strobes; zero wait state.
REQ-007 s_writedata  in  32  CSR write data.
REQ-008 s_readdata  out  32  CSR read data, combinational from s_address.
REQ-009 h_address  in  2  host pass-through address to the PIO.
REQ-010 h_chipselect, h_write_n  in  1 each  host pass-through strobes.
REQ-011 h_writedata  in  32  host pass-through write data.
REQ-012 h_readdata  out  32  equals m_readdata at all times.
REQ-013 m_address  out  2  PIO master address.
REQ-014 m_chipselect, m_write_n  out  1 each  PIO master strobes; the PIO never inserts wait states.
REQ-015 m_writedata  out  32  PIO master write data.
REQ-016 m_readdata  in  32  PIO read data.

Function
REQ-017 CTRL: bit0 EN, bit1 ONESHOT; other bits read 0.
REQ-018 PERIOD: clk cycles between successive pattern writes; the value 0 SHALL be treated as 1.
REQ-019 PATTERN: bit sequence sent LSB first; bit i is written as m_writedata = {31'b0, PATTERN[i]}, m_address = 0.
REQ-020 STATUS: bit0 BUSY (state != IDLE), bits 12:8 IDX, bit16 DONE (sticky); a write with bit16 = 1 SHALL clear DONE, and all other STATUS bits are read-only.
REQ-021 FSM states SHALL be IDLE, WRITE and WAIT.
REQ-022 IDLE -> WRITE on the cycle after a CTRL write with EN = 1; IDX SHALL be cleared to 0 on that write.
REQ-023 WRITE SHALL drive m_chipselect = 1 and m_write_n = 0 for exactly one cycle when not preempted.
  - Then IDX increments and the counter loads PERIOD-1.
  - Next state is WAIT.
REQ-024 WAIT SHALL decrement the counter each cycle and go to WRITE when it equals 0, so successive pattern writes are exactly PERIOD cycles apart.
REQ-025 IDX SHALL wrap 31 -> 0 when ONESHOT = 0.
REQ-026 When ONESHOT = 1, after the write of bit 31 the block SHALL clear EN, set DONE and go to IDLE.
REQ-027 A CTRL write with EN = 0 SHALL force IDLE on the next cycle, with no further master write; the PIO keeps its last value.
REQ-028 A CTRL write with EN = 1 while running SHALL restart from IDX 0 with an immediate WRITE.
REQ-029 PERIOD and PATTERN writes while running SHALL take effect at the next counter reload and the next WRITE respectively; no restart.
REQ-030 Host priority: when h_chipselect = 1, h_address, h_chipselect, h_write_n and h_writedata SHALL drive the m_* outputs combinationally in the same cycle.
  - A sequencer WRITE in that cycle is stalled: it stays in WRITE, and IDX and the counter hold.
  - The stalled write issues in the first cycle with h_chipselect = 0.
REQ-031 When neither host nor sequencer is active, m_chipselect = 0, m_write_n = 1, m_address = 0 and m_writedata = 0.
REQ-032 Counter and IDX arithmetic SHALL be unsigned modulo 2^32 and 2^5 respectively; the counter never underflows.

Reset
REQ-033 While reset_n = 0, the block SHALL hold:
  - state IDLE, CTRL = 0, PERIOD = DEFAULT_PERIOD, PATTERN = DEFAULT_PATTERN;
  - IDX = 0, DONE = 0, counter = 0;
  - m_* outputs at their REQ-031 idle values.
REQ-034 Reset asserted mid-WRITE or mid-WAIT SHALL abort the operation immediately; no master write occurs until EN is written again after reset release.

Verification
REQ-035 Reset, read all CSRs -> 0, 50_000_000, 0x5555_5555, 0; m_chipselect = 0.
REQ-036 PERIOD = 4, PATTERN = 0x6, CTRL = 1 at cycle T -> master writes at T+1, T+5, T+9, T+13 with data 0, 1, 1, 0; STATUS.IDX = 4 after the fourth write.
REQ-037 PERIOD = 1, PATTERN = 0xFFFF_FFFF, CTRL = 3 -> 32 back-to-back writes of 1, then BUSY = 0, EN = 0 and DONE = 1; writing STATUS = 0x1_0000 clears DONE.
REQ-038 Running with PERIOD = 2, host writes 0x1 on the cycle the sequencer's WRITE is due -> host write appears on m_*, the sequencer write follows on the next cycle, and subsequent spacing is unchanged.
REQ-039 PERIOD = 0 -> writes every cycle, same as PERIOD = 1; with ONESHOT = 0, IDX wraps 31 -> 0.
REQ-040 CTRL = 0 written in WAIT, or reset_n pulsed in WAIT -> no further m_chipselect; BUSY = 0 on the next cycle.

Source files
------------

// File: rtl/pio_blink_ctrl.sv
// pio_blink_ctrl: CSR-programmable sequencer that writes a 32-bit pattern, one bit at a
// time, to a PIO through a master port. Host accesses to the PIO are passed through with
// priority over the sequencer.
module pio_blink_ctrl #(
    parameter logic [31:0] DEFAULT_PERIOD  = 32'd50_000_000,
    parameter logic [31:0] DEFAULT_PATTERN = 32'h5555_5555
) (
    input  logic        clk,
    input  logic        reset_n,
    // CSR slave
    input  logic [1:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    // host pass-through slave
    input  logic [1:0]  h_address,
    input  logic        h_chipselect,
    input  logic        h_write_n,
    input  logic [31:0] h_writedata,
    output logic [31:0] h_readdata,
    // PIO master
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_PERIOD  = 2'd1;
    localparam logic [1:0] A_PATTERN = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic [1:0]        ctrl_q,    ctrl_d;     // [0] EN, [1] ONESHOT
    logic [DATA_W-1:0] period_q,  period_d;
    logic [DATA_W-1:0] pattern_q, pattern_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic              done_q,    done_d;
    logic [DATA_W-1:0] cnt_q,     cnt_d;

    logic              csr_wr;
    logic [DATA_W-1:0] period_eff;

    assign csr_wr     = s_chipselect & ~s_write_n;
    assign period_eff = (period_q == '0) ? DATA_W'(1) : period_q;
    assign h_readdata = m_readdata;

    // State and CSR registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= 2'b00;
            period_q  <= DEFAULT_PERIOD;
            pattern_q <= DEFAULT_PATTERN;
            idx_q     <= '0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            period_q  <= period_d;
            pattern_q <= pattern_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state: sequencer progress first, then a CTRL write overrides it
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        period_d  = period_q;
        pattern_d = pattern_q;
        idx_d     = idx_q;
        done_d    = done_q;
        cnt_d     = cnt_q;

        if (csr_wr && s_address == A_PERIOD)  period_d  = s_writedata;
        if (csr_wr && s_address == A_PATTERN) pattern_d = s_writedata;
        if (csr_wr && s_address == A_STATUS && s_writedata[16]) done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
            end
            ST_WRITE: begin
                // a host access owns the bus this cycle; the sequencer write waits
                if (!h_chipselect) begin
                    idx_d = idx_q + IDX_W'(1);
                    cnt_d = period_eff - DATA_W'(1);
                    if (ctrl_q[1] && idx_q == IDX_W'(31)) begin
                        state_d   = ST_IDLE;
                        ctrl_d[0] = 1'b0;
                        done_d    = 1'b1;
                    end else if (period_eff == DATA_W'(1)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= DATA_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q - DATA_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (csr_wr && s_address == A_CTRL) begin
            ctrl_d = s_writedata[1:0];
            if (s_writedata[0]) begin
                state_d = ST_WRITE;
                idx_d   = '0;
                cnt_d   = '0;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Master port mux: host has priority, then the sequencer, else idle
    always_comb begin
        m_address    = 2'b00;
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_writedata  = '0;
        if (h_chipselect) begin
            m_address    = h_address;
            m_chipselect = 1'b1;
            m_write_n    = h_write_n;
            m_writedata  = h_writedata;
        end else if (state_q == ST_WRITE) begin
            m_chipselect = 1'b1;
            m_write_n    = 1'b0;
            m_writedata  = {31'b0, pattern_q[idx_q]};
        end
    end

    // CSR read mux
    always_comb begin
        s_readdata = '0;
        case (s_address)
            A_CTRL:    s_readdata = {30'b0, ctrl_q};
            A_PERIOD:  s_readdata = period_q;
            A_PATTERN: s_readdata = pattern_q;
            default:   s_readdata = {15'b0, done_q, 3'b0, idx_q, 7'b0, (state_q != ST_IDLE)};
        endcase
    end

endmodule

// File: tb/tb_pio_blink_ctrl.sv
// Bench for pio_blink_ctrl: table-driven reset reads, directed multi-cycle sequences and
// randomized traffic, all checked every cycle against a write-schedule reference model.
module tb_pio_blink_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  s_address;
    logic        s_chipselect, s_write_n;
    logic [31:0] s_writedata, s_readdata;
    logic [1:0]  h_address;
    logic        h_chipselect, h_write_n;
    logic [31:0] h_writedata, h_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect, m_write_n;
    logic [31:0] m_writedata, m_readdata;

    always #5 clk = ~clk;

    pio_blink_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .h_address(h_address), .h_chipselect(h_chipselect), .h_write_n(h_write_n),
        .h_writedata(h_writedata), .h_readdata(h_readdata),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    // Reference model: the sequencer is described by when its next write is due
    // (an absolute cycle number), which bit it sends, and the CSR contents.
    bit          md_en, md_os, md_done;
    logic [31:0] md_period, md_pattern;
    int          md_idx;
    int          md_due;

    logic [31:0] last_rd;
    int          wr_cyc[$];
    logic [31:0] wr_dat[$];

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;
    rd_vec_t rst_tab[4];

    task automatic model_reset();
        md_en = 0; md_os = 0; md_done = 0;
        md_period = 32'd50_000_000; md_pattern = 32'h5555_5555;
        md_idx = 0; md_due = 0;
    endtask

    function automatic logic [31:0] model_rd(logic [1:0] a);
        case (a)
            2'd0:    return {30'b0, md_os, md_en};
            2'd1:    return md_period;
            2'd2:    return md_pattern;
            default: return {15'b0, md_done, 3'b0, 5'(md_idx), 7'b0, md_en};
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle with the currently driven inputs, checked against the model.
    task automatic step();
        logic [3:0]  e_ctl;
        logic [31:0] e_wd, e_rd;
        bit          due, seq_wr, csr_wr;
        @(negedge clk);
        due    = md_en && (cyc >= md_due);
        seq_wr = due && !h_chipselect;
        if (h_chipselect) begin
            e_ctl = {h_address, 1'b1, h_write_n};
            e_wd  = h_writedata;
        end else if (due) begin
            e_ctl = 4'b0010;
            e_wd  = {31'b0, md_pattern[md_idx]};
        end else begin
            e_ctl = 4'b0001;
            e_wd  = 32'h0;
        end
        e_rd = model_rd(s_address);
        chk("m_ctl", 32'({m_address, m_chipselect, m_write_n}), 32'(e_ctl));
        chk("m_writedata", m_writedata, e_wd);
        chk("s_readdata", s_readdata, e_rd);
        chk("h_readdata", h_readdata, m_readdata);
        last_rd = s_readdata;
        if (m_chipselect && !m_write_n) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(m_writedata);
        end
        @(posedge clk);
        csr_wr = s_chipselect && !s_write_n;
        if (csr_wr && s_address == 2'd3 && s_writedata[16]) md_done = 0;
        if (seq_wr) begin
            if (md_os && md_idx == 31) begin
                md_en = 0; md_done = 1;
            end
            md_idx = (md_idx + 1) % 32;
            md_due = cyc + ((md_period == 0) ? 1 : int'(md_period));
        end
        if (csr_wr && s_address == 2'd1) md_period  = s_writedata;
        if (csr_wr && s_address == 2'd2) md_pattern = s_writedata;
        if (csr_wr && s_address == 2'd0) begin
            md_en = s_writedata[0];
            md_os = s_writedata[1];
            if (s_writedata[0]) begin
                md_idx = 0;
                md_due = cyc + 1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle_steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic csr_write(logic [1:0] a, logic [31:0] d);
        s_address = a; s_chipselect = 1'b1; s_write_n = 1'b0; s_writedata = d;
        step();
        s_chipselect = 1'b0; s_write_n = 1'b1; s_writedata = 32'h0;
    endtask

    task automatic csr_read(logic [1:0] a);
        s_address = a;
        step();
        s_address = 2'd0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_m_cs", 32'(m_chipselect), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        int t0;
        reset_n = 1'b0;
        s_address = 2'd0; s_chipselect = 1'b0; s_write_n = 1'b1; s_writedata = 32'h0;
        h_address = 2'd0; h_chipselect = 1'b0; h_write_n = 1'b1; h_writedata = 32'h0;
        m_readdata = 32'h0;
        model_reset();
        rst_tab[0] = '{2'd0, 32'h0};
        rst_tab[1] = '{2'd1, 32'd50_000_000};
        rst_tab[2] = '{2'd2, 32'h5555_5555};
        rst_tab[3] = '{2'd3, 32'h0};
        repeat (2) @(posedge clk);
        do_reset();

        // reset values of every CSR
        foreach (rst_tab[i]) begin
            csr_read(rst_tab[i].addr);
            chk("rst_csr", last_rd, rst_tab[i].exp);
        end

        // PERIOD 4, PATTERN 0x6: writes at T+1, +5, +9, +13 with 0,1,1,0
        csr_write(2'd1, 32'd4);
        csr_write(2'd2, 32'h6);
        t0 = cyc;
        wr_cyc.delete(); wr_dat.delete();
        csr_write(2'd0, 32'h1);
        idle_steps(13);
        chk("p4_nwrites", 32'(wr_cyc.size()), 32'd4);
        if (wr_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("p4_time", 32'(wr_cyc[i] - t0), 32'(1 + 4 * i));
            end
            chk("p4_data", {28'b0, wr_dat[3][0], wr_dat[2][0], wr_dat[1][0], wr_dat[0][0]}, 32'h6);
        end
        csr_read(2'd3);
        chk("p4_status", last_rd, 32'h0000_0401);
        csr_write(2'd0, 32'h0);

        // one-shot, PERIOD 1: 32 back-to-back ones, then DONE
        csr_write(2'd1, 32'd1);
        csr_write(2'd2, 32'hFFFF_FFFF);
        wr_cyc.delete(); wr_dat.delete();
        csr_write(2'd0, 32'h3);
        idle_steps(36);
        chk("os_nwrites", 32'(wr_cyc.size()), 32'd32);
        if (wr_cyc.size() == 32) chk("os_span", 32'(wr_cyc[31] - wr_cyc[0]), 32'd31);
        csr_read(2'd3);
        chk("os_status", last_rd, 32'h0001_0000);
        csr_read(2'd0);
        chk("os_ctrl", last_rd, 32'h2);
        csr_write(2'd3, 32'h0001_0000);
        csr_read(2'd3);
        chk("os_done_clr", last_rd, 32'h0);

        // host collides with a due sequencer write at PERIOD 2
        csr_write(2'd1, 32'd2);
        csr_write(2'd2, 32'h0);
        wr_cyc.delete(); wr_dat.delete();
        t0 = cyc;
        csr_write(2'd0, 32'h1);
        idle_steps(2);
        h_chipselect = 1'b1; h_write_n = 1'b0; h_writedata = 32'h1; h_address = 2'd0;
        step();
        h_chipselect = 1'b0; h_write_n = 1'b1; h_writedata = 32'h0;
        idle_steps(3);
        chk("hp_nwrites", 32'(wr_cyc.size()), 32'd4);
        if (wr_cyc.size() == 4) begin
            chk("hp_t1", 32'(wr_cyc[1] - t0), 32'd3);
            chk("hp_d1", wr_dat[1], 32'h1);
            chk("hp_t2", 32'(wr_cyc[2] - t0), 32'd4);
            chk("hp_t3", 32'(wr_cyc[3] - t0), 32'd6);
        end
        csr_write(2'd0, 32'h0);

        // PERIOD 0 behaves as 1; IDX wraps
        csr_write(2'd1, 32'd0);
        csr_write(2'd2, 32'hA5C3_0F96);
        wr_cyc.delete(); wr_dat.delete();
        csr_write(2'd0, 32'h1);
        idle_steps(33);
        chk("p0_nwrites", 32'(wr_cyc.size()), 32'd33);
        csr_read(2'd3);
        chk("p0_wrap", last_rd, 32'h0000_0101);

        // stop from WAIT via CTRL=0
        csr_write(2'd1, 32'd5);
        csr_write(2'd0, 32'h1);
        idle_steps(3);
        csr_write(2'd0, 32'h0);
        wr_cyc.delete(); wr_dat.delete();
        csr_read(2'd3);
        chk("stop_busy", 32'(last_rd[0]), 32'h0);
        idle_steps(10);
        chk("stop_quiet", 32'(wr_cyc.size()), 32'd0);

        // reset pulse in WAIT
        csr_write(2'd0, 32'h1);
        idle_steps(3);
        do_reset();
        wr_cyc.delete(); wr_dat.delete();
        csr_read(2'd3);
        chk("rst_busy", last_rd, 32'h0);
        idle_steps(60);
        chk("rst_quiet", 32'(wr_cyc.size()), 32'd0);
        csr_read(2'd1);
        chk("rst_period", last_rd, 32'd50_000_000);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic [1:0] a;
            a = 2'($urandom_range(0, 3));
            s_address    = a;
            s_chipselect = 1'b0;
            s_write_n    = 1'b1;
            s_writedata  = 32'h0;
            if ($urandom_range(0, 9) == 0) begin
                s_chipselect = 1'b1;
                s_write_n    = 1'b0;
                case (a)
                    2'd0:    s_writedata = 32'($urandom_range(0, 3)) | ($urandom & 32'hFFFF_FFF0);
                    2'd1:    s_writedata = 32'($urandom_range(0, 4));
                    default: s_writedata = $urandom;
                endcase
            end else begin
                s_chipselect = 1'($urandom_range(0, 1));
            end
            h_chipselect = ($urandom_range(0, 5) == 0);
            h_address    = 2'($urandom_range(0, 3));
            h_write_n    = 1'($urandom_range(0, 1));
            h_writedata  = $urandom;
            m_readdata   = $urandom;
            step();
        end
        s_chipselect = 1'b0; s_write_n = 1'b1; h_chipselect = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
